// File: rtl/mont_red_arbiter.sv
// ============================================================================
//  Module   : mont_red_arbiter
//  Purpose  : Shares one fixed-latency Montgomery reduction unit between two
//             requesters. Grants round-robin, latches the winner's operands
//             onto the unit inputs, pulses the unit's synchronous reset to
//             restart its stage sequencer, waits LATENCY cycles, then returns
//             the captured result with a one-cycle done pulse.
//
//  Ports    : clk                 rising-edge clock
//             rst                 asynchronous reset, active low
//             req0/req1           level requests
//             x*/m*/minv*         requester operands (latched at grant)
//             done0/done1         one-cycle result-valid pulses
//             result              captured reduction result
//             busy                high outside IDLE
//             grant               index of the current/last served requester
//             ru_rst              synchronous active-high unit reset
//             ru_x/ru_m/ru_minv   operands driven to the unit
//             ru_xred             unit result
//
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mont_red_arbiter #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 8,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] m0,
   input  logic [WIDTH-1:0] minv0,
   input  logic             req1,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] m1,
   input  logic [WIDTH-1:0] minv1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             grant,
   output logic             ru_rst,
   output logic [WIDTH-1:0] ru_x,
   output logic [WIDTH-1:0] ru_m,
   output logic [WIDTH-1:0] ru_minv,
   input  logic [WIDTH-1:0] ru_xred
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Counter value at which the unit output is sampled (last RUN cycle).
   localparam logic [CNT_W-1:0] c_last = CNT_W'(LATENCY - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done0;
   logic             r_done1;
   logic [WIDTH-1:0] r_result;
   logic             r_busy;
   logic             r_grant;
   logic             r_ru_rst;
   logic [WIDTH-1:0] r_ru_x;
   logic [WIDTH-1:0] r_ru_m;
   logic [WIDTH-1:0] r_ru_minv;

   logic             w_any;
   logic             w_sel;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_m;
   logic [WIDTH-1:0] w_minv;

   // Arbitration: a lone request wins outright; on a tie the requester that
   // was not served last wins. grant resets to 1 so requester 0 takes the
   // first tie after reset.
   assign w_any  = req0 | req1;
   assign w_sel  = (req0 & req1) ? ~r_grant : req1;
   assign w_x    = w_sel ? x1    : x0;
   assign w_m    = w_sel ? m1    : m0;
   assign w_minv = w_sel ? minv1 : minv0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_result  <= '0;
         r_busy    <= 1'b0;
         r_grant   <= 1'b1;
         r_ru_rst  <= 1'b1;
         r_ru_x    <= '0;
         r_ru_m    <= '0;
         r_ru_minv <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Unit stays in reset whenever it is not running.
               r_ru_rst <= 1'b1;
               r_done0  <= 1'b0;
               r_done1  <= 1'b0;
               r_cnt    <= '0;
               if (w_any) begin
                  r_grant   <= w_sel;
                  r_ru_x    <= w_x;
                  r_ru_m    <= w_m;
                  r_ru_minv <= w_minv;
                  r_busy    <= 1'b1;
                  r_state   <= S_LOAD;
               end else begin
                  r_busy <= 1'b0;
               end
            end

            S_LOAD: begin
               // One cycle of unit reset with the new operands already
               // stable, so the unit's sequencer restarts on clean inputs.
               r_cnt    <= '0;
               r_ru_rst <= 1'b0;
               r_state  <= S_RUN;
            end

            S_RUN: begin
               if (r_cnt == c_last) begin
                  r_result <= ru_xred;
                  r_done0  <= ~r_grant;
                  r_done1  <= r_grant;
                  r_ru_rst <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_DONE: begin
               r_done0 <= 1'b0;
               r_done1 <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_done0  <= 1'b0;
               r_done1  <= 1'b0;
               r_busy   <= 1'b0;
               r_ru_rst <= 1'b1;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign done0   = r_done0;
   assign done1   = r_done1;
   assign result  = r_result;
   assign busy    = r_busy;
   assign grant   = r_grant;
   assign ru_rst  = r_ru_rst;
   assign ru_x    = r_ru_x;
   assign ru_m    = r_ru_m;
   assign ru_minv = r_ru_minv;

endmodule

`default_nettype wire

// File: tb/tb_mont_red_arbiter.sv
// ============================================================================
//  Module   : tb_mont_red_arbiter
//  Purpose  : Self-checking bench for mont_red_arbiter. A behavioural model
//             of the reduction unit returns ru_x+1 once it has run long
//             enough, else 32'hDEADBEEF. Expected (requester, result) pairs
//             are queued when stimulus is issued; a monitor pops and compares
//             on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mont_red_arbiter;

   localparam int W   = 32;
   localparam int LAT = 8;
   localparam int CW  = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] x0 = '0, m0 = '0, minv0 = '0;
   logic [W-1:0] x1 = '0, m1 = '0, minv1 = '0;
   logic         done0, done1, busy, grant, ru_rst;
   logic [W-1:0] result, ru_x, ru_m, ru_minv, ru_xred;

   mont_red_arbiter #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .x0(x0), .m0(m0), .minv0(minv0),
      .req1(req1), .x1(x1), .m1(m1), .minv1(minv1),
      .done0(done0), .done1(done1), .result(result), .busy(busy),
      .grant(grant), .ru_rst(ru_rst),
      .ru_x(ru_x), .ru_m(ru_m), .ru_minv(ru_minv), .ru_xred(ru_xred)
   );

   always #5 clk = ~clk;

   // Reduction unit model: counts cycles out of reset, valid after LAT-1.
   int ucnt = 0;
   always @(posedge clk) begin
      if (ru_rst)             ucnt <= 0;
      else if (ucnt < LAT-1)  ucnt <= ucnt + 1;
   end
   assign ru_xred = (ucnt == LAT-1) ? ru_x + 32'h1 : 32'hDEADBEEF;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct { bit id; logic [W-1:0] res; } exp_t;
   exp_t         exp_q[$];
   bit           last_grant = 1'b1;
   logic [W-1:0] last_res   = '0;
   bit           spacing_on = 1'b0;
   bit           have_prev  = 1'b0;
   int           prev_cyc   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   task automatic push_exp(input bit id, input logic [W-1:0] r);
      exp_t e;
      e.id  = id;
      e.res = r;
      exp_q.push_back(e);
      last_res = r;
   endtask

   // Monitor: every done pulse must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (done0 || done1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'({done1, done0}), 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("done_id", 64'({done1, done0}), e.id ? 64'd2 : 64'd1);
               check("grant", 64'(grant), 64'(e.id));
               check("result", 64'(result), 64'(e.res));
               if (spacing_on) begin
                  if (have_prev) check("done_spacing", 64'(cyc - prev_cyc), 64'(LAT + 3));
                  prev_cyc  = cyc;
                  have_prev = 1'b1;
               end
            end
         end
      end
   end

   // One batch: assert the chosen requests, expect round-robin service,
   // drop each request on its done. Single-request batches may scramble
   // operands once the unit is busy to show operands were latched.
   task automatic batch(input bit r0, input bit r1, input logic [W-1:0] a0,
                        input logic [W-1:0] a1, input bit scramble);
      bit first;
      bit timed_out;
      if (r0 && r1) begin
         first = ~last_grant;
         push_exp(first,  (first ? a1 : a0) + 32'h1);
         push_exp(~first, (first ? a0 : a1) + 32'h1);
         last_grant = ~first;
      end else if (r0) begin
         push_exp(1'b0, a0 + 32'h1);
         last_grant = 1'b0;
      end else begin
         push_exp(1'b1, a1 + 32'h1);
         last_grant = 1'b1;
      end
      x0 = a0; m0 = $urandom; minv0 = $urandom;
      x1 = a1; m1 = $urandom; minv1 = $urandom;
      req0 = r0; req1 = r1;
      timed_out = 1'b1;
      for (int i = 0; i < 3*(LAT+3); i++) begin
         @(negedge clk);
         if (done0) req0 = 1'b0;
         if (done1) req1 = 1'b0;
         if (!req0 && !req1) begin
            timed_out = 1'b0;
            break;
         end
         if (scramble && busy && !(r0 && r1)) begin
            x0 = $urandom; m0 = $urandom; minv0 = $urandom;
            x1 = $urandom; m1 = $urandom; minv1 = $urandom;
         end
      end
      check("batch_timeout", 64'(timed_out), 64'd0);
      req0 = 1'b0; req1 = 1'b0;
   endtask

   // Both requests held for six operations: strict alternation, fixed spacing.
   task automatic fairness();
      bit           s;
      bit           id;
      bit           timed_out;
      int           n;
      logic [W-1:0] a0, a1;
      s  = ~last_grant;
      a0 = $urandom;
      a1 = $urandom;
      for (int k = 0; k < 6; k++) begin
         id = (k % 2 == 0) ? s : ~s;
         push_exp(id, (id ? a1 : a0) + 32'h1);
      end
      last_grant = ~s;
      x0 = a0; x1 = a1;
      spacing_on = 1'b1; have_prev = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      n = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 6*(LAT+3)+10; i++) begin
         @(negedge clk);
         if (done0 || done1) n++;
         if (n == 6) begin
            req0 = 1'b0; req1 = 1'b0;
            timed_out = 1'b0;
            break;
         end
      end
      check("fairness_timeout", 64'(timed_out), 64'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      spacing_on = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_done0", 64'(done0), 64'd0);
      check("rst_done1", 64'(done1), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_grant", 64'(grant), 64'd1);
      check("rst_ru_rst", 64'(ru_rst), 64'd1);
      check("rst_ru_x", 64'(ru_x), 64'd0);
      check("rst_ru_m", 64'(ru_m), 64'd0);
      check("rst_ru_minv", 64'(ru_minv), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Tie after reset: requester 0 first, then 1.
      batch(1'b1, 1'b1, 32'd5, 32'd9, 1'b0);

      // Single request, exact timing.
      repeat (2) @(negedge clk);
      x0 = 32'h10; m0 = 32'd13; minv0 = 32'd1; req0 = 1'b1;
      push_exp(1'b0, 32'h11);
      last_grant = 1'b0;
      for (int k = 1; k <= LAT+3; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("load_ru_rst", 64'(ru_rst), 64'd1);
            check("load_busy", 64'(busy), 64'd1);
         end
         if (k == 2) check("run_ru_rst", 64'(ru_rst), 64'd0);
         if (k == LAT+1) check("done0_early", 64'(done0), 64'd0);
         if (k == LAT+2) begin
            check("done0_on_time", 64'(done0), 64'd1);
            check("done1_quiet", 64'(done1), 64'd0);
            req0 = 1'b0;
         end
         if (k == LAT+3) begin
            check("done0_one_cycle", 64'(done0), 64'd0);
            check("busy_after_done", 64'(busy), 64'd0);
         end
      end

      // Operand isolation: x0 changes during RUN.
      repeat (2) @(negedge clk);
      x0 = 32'd7; req0 = 1'b1;
      push_exp(1'b0, 32'd8);
      last_grant = 1'b0;
      for (int k = 1; k <= LAT+2; k++) begin
         @(negedge clk);
         if (k == 3) x0 = 32'd99;
         if (k == 4) check("ru_x_isolated", 64'(ru_x), 64'd7);
         if (k == LAT+2) req0 = 1'b0;
      end
      req0 = 1'b0;

      // Fairness under continuous requests.
      repeat (2) @(negedge clk);
      fairness();

      // Reset mid-RUN (counter = 3): request lost, no done.
      repeat (2) @(negedge clk);
      x0 = $urandom; req0 = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0; req0 = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_ru_rst", 64'(ru_rst), 64'd1);
      check("midrst_done", 64'({done1, done0}), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      last_grant = 1'b1;
      last_res   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (LAT+5) @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);
      batch(1'b1, 1'b0, $urandom, $urandom, 1'b0);

      // Randomized batches.
      for (int t = 0; t < 25; t++) begin
         int unsigned pat;
         pat = $urandom_range(1, 3);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         batch(pat[0], pat[1], $urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      // Idle hold: unit stays in reset, result register untouched.
      repeat (2) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("idle_ru_rst", 64'(ru_rst), 64'd1);
         check("idle_busy", 64'(busy), 64'd0);
         check("idle_result", 64'(result), 64'(last_res));
      end

      check("all_results_delivered", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mont_red_arbiter.md
Name: mont_red_arbiter

Overview:
- Sequences and shares one Montgomery reduction unit (x, m, m_inv in; x_red out; synchronous active-high unit reset; fixed latency, no handshake) between two requesters.
- Grants the unit round-robin and holds operands stable on the unit inputs.
- Pulses the unit's reset to restart its stage sequencer, waits a fixed latency, then returns the captured result with a one-cycle done pulse.
- Sits between the security accelerator's key-schedule/exponentiation engines and the shared reduction datapath.

Parameters:
- WIDTH, 32, operand/result width.
- LATENCY, 8, clock cycles spent in RUN before x_red is sampled; must be >= 2.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > LATENCY.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req0  input  1  requester 0 request, level.
- x0, m0, minv0  input  WIDTH each  requester 0 operands.
- req1  input  1  requester 1 request, level.
- x1, m1, minv1  input  WIDTH each  requester 1 operands.
- done0  output  1  one-cycle pulse, result for requester 0 valid.
- done1  output  1  one-cycle pulse, result for requester 1 valid.
- result  output  WIDTH  reduction result, valid while done0|done1.
- busy  output  1  high in any state other than IDLE.
- grant  output  1  index of the currently/last served requester.
- ru_rst  output  1  synchronous active-high reset to the reduction unit.
- ru_x, ru_m, ru_minv  output  WIDTH each  operands to the reduction unit.
- ru_xred  input  WIDTH  reduction unit result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all of done0, done1, busy and result are 0.
  - grant=1, so requester 0 wins the first tie.
  - ru_rst=1, and ru_x/ru_m/ru_minv=0.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE:
  - Both req low: stay in IDLE with ru_rst=1 (unit held in reset).
  - One req high: grant it.
  - Both high: grant the requester not equal to grant (round-robin).
- On grant: capture that requester's x/m/minv into the ru_* registers, update grant, go to LOAD.
- LOAD (1 cycle): ru_rst=1 with operands stable; counter cleared; go to RUN.
- RUN:
  - ru_rst=0; counter increments each cycle.
  - At the edge where counter==LATENCY-1: result<=ru_xred, raise done[grant], go to DONE.
- DONE (1 cycle):
  - done[grant]=1 and result valid.
  - Next edge: done cleared, go to IDLE.
  - result holds its value until the next capture.
- Timing:
  - Req sampled at edge t0 → done high in the cycle following edge t0+LATENCY+1.
  - Minimum request-to-request spacing is LATENCY+3 cycles.
- Operands are latched at grant. Requester operand changes after grant have no effect.
- Requester protocol:
  - Hold req high until done.
  - Deassert req at or before the edge ending the done cycle, or the request is treated as a new one.
  - A req dropped mid-operation does not abort; result and done are still delivered.
- Simultaneous events:
  - A req arriving during LOAD/RUN/DONE waits; it is evaluated in IDLE.
  - Continuous req0 and req1 alternate grants strictly: 0,1,0,1…
- Reset mid-operation:
  - Immediate return to IDLE; no done is issued.
  - ru_rst=1; the in-flight request is lost and the requester must re-request.
- busy=1 in LOAD, RUN and DONE.
- done0 and done1 are never high together.

Test Plan:
- Bench model of the unit returns ru_xred = ru_x + 32'h1 after LATENCY-1 cycles out of ru_rst=0, else 32'hDEADBEEF.
- Single request: req0=1, x0=32'h10, m0=32'd13, minv0=32'd1 at t0 → ru_rst=1 for 1 cycle; done0 pulses for exactly one cycle at t0+LATENCY+2 with result=32'h11; done1 stays 0; busy falls the cycle after done0.
- Tie after reset: req0 and req1 rise on the same edge (x0=5, x1=9) → requester 0 served first (result=6, done0), then requester 1 (result=10, done1); grant sequence is 0,1.
- Fairness: req0 and req1 held high for 6 operations → grants alternate 0,1,0,1,0,1; spacing between done pulses is exactly LATENCY+3 cycles.
- Operand isolation: x0 changed from 7 to 99 during RUN → ru_x remains 7 and result=8.
- Reset mid-RUN: rst low for 2 cycles at RUN counter=3 → busy=0, ru_rst=1 and no done pulse; re-request after reset gives the correct result.
- Idle hold: no requests for 20 cycles → ru_rst stays 1, busy=0, and the result register is unchanged.
